// File: rtl/dual_cpu_top.sv
// dual_cpu_top: line-request arbiter and bmem burst sequencer shared by two cores.
// Core 0 (in-order pipeline) and core 1 (out-of-order) attach through the
// core_*_i / core_*_o line-request ports: req, we, addr, wdata -> resp, rdata.
// A request is held until its one-cycle resp. Exactly one transaction is in
// flight at a time, and it is carried out as a burst of BEATS beats on bmem.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, ties are
// resolved round-robin. When it is undefined, core 0 has fixed priority.
module dual_cpu_top #(
  parameter  int ADDR_W = 32,
  parameter  int BEAT_W = 64,
  parameter  int BEATS  = 4,
  localparam int LINE_W = BEATS * BEAT_W,
  localparam int CNT_W  = $clog2(BEATS),
  localparam int OFF_W  = $clog2(LINE_W / 8)
) (
  input  logic                          clk,
  input  logic                          rst,
  // bmem port
  output logic [ADDR_W-1:0]             bmem_addr,
  output logic                          bmem_read,
  output logic                          bmem_write,
  output logic [BEAT_W-1:0]             bmem_wdata,
  input  logic                          bmem_ready,
  input  logic [ADDR_W-1:0]             bmem_raddr,
  input  logic [BEAT_W-1:0]             bmem_rdata,
  input  logic                          bmem_rvalid,
  // per-core line-request ports (index 0 = pipeline core, 1 = ooo core)
  input  logic [1:0]                    core_req_i,
  input  logic [1:0]                    core_we_i,
  input  logic [1:0][ADDR_W-1:0]        core_addr_i,
  input  logic [1:0][LINE_W-1:0]        core_wdata_i,
  output logic [1:0]                    core_resp_o,
  output logic [LINE_W-1:0]             core_rdata_o
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_e;

  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          gnt_q, gnt_d;
  logic                          we_q, we_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [BEATS-1:0][BEAT_W-1:0]  line_q, line_d;
  logic                          gnt_sel;
  logic                          last_beat;

  assign last_beat = (cnt_q == LAST_BEAT);

`ifdef ARB_ROUND_ROBIN_EN
  // Index of the core that wins a tie. After every grant it points at the
  // core that was not granted.
  logic rr_q;

  assign gnt_sel = (&core_req_i) ? rr_q : core_req_i[1];

  // Move the round-robin pointer whenever a grant is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else if (state_q == IDLE && |core_req_i) begin
      rr_q <= ~gnt_sel;
    end
  end
`else
  // Fixed priority: core 0 wins whenever it is requesting.
  assign gnt_sel = ~core_req_i[0];
`endif

  // State and datapath registers.
  // NOTE: the line buffer is reset along with the control state. It is small,
  // and it feeds core_rdata_o directly, so a known value after reset keeps that
  // output clean. A true memory array would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      // NOTE: sequential state is assigned non-blocking so that every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state, burst sequencing and bmem/core handshakes.
  always_comb begin
    // NOTE: every variable gets a default here, so that no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    line_d      = line_q;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_wdata  = '0;
    core_resp_o = '0;

    unique case (state_q)
      IDLE: begin
        if (|core_req_i) begin
          gnt_d   = gnt_sel;
          we_d    = core_we_i[gnt_sel];
          addr_d  = core_addr_i[gnt_sel] & ~OFF_MASK;
          line_d  = core_wdata_i[gnt_sel];
          cnt_d   = '0;
          state_d = core_we_i[gnt_sel] ? WR : RD_REQ;
        end
      end
      WR: begin
        bmem_write = 1'b1;
        bmem_wdata = line_q[cnt_q];
        if (bmem_ready) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = RESP;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Beats that belong to some other line are dropped silently.
        if (bmem_rvalid && bmem_raddr == addr_q) begin
          line_d[cnt_q] = bmem_rdata;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        core_resp_o[gnt_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bmem_addr    = addr_q;
  assign core_rdata_o = line_q;

endmodule

// File: tb/tb_dual_cpu_top.sv
// tb_dual_cpu_top: randomized scoreboard bench for dual_cpu_top.
// The drivers issue line requests. At issue time, the expected response is
// taken from a line-granular reference memory image and pushed onto a
// per-core queue. A monitor pops and compares each resp as it appears. A
// behavioural bmem responder stalls ready at random, returns read beats with
// gaps and injects stray beats for foreign lines.
`timescale 1ns/1ps
module tb_dual_cpu_top;
  localparam int ADDR_W = 32;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEATS * BEAT_W;

  typedef struct {
    logic              we;
    logic [31:0]       line;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [ADDR_W-1:0]       bmem_addr;
  logic                    bmem_read, bmem_write;
  logic [BEAT_W-1:0]       bmem_wdata;
  logic                    bmem_ready, bmem_rvalid;
  logic [ADDR_W-1:0]       bmem_raddr;
  logic [BEAT_W-1:0]       bmem_rdata;
  logic [1:0]              c_req, c_we, core_resp_o;
  logic [1:0][ADDR_W-1:0]  c_addr;
  logic [1:0][LINE_W-1:0]  c_wdata;
  logic [LINE_W-1:0]       core_rdata_o;

  always #5 clk = ~clk;

  dual_cpu_top dut (
    .clk(clk), .rst(rst),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
    .core_req_i(c_req), .core_we_i(c_we), .core_addr_i(c_addr),
    .core_wdata_i(c_wdata), .core_resp_o(core_resp_o), .core_rdata_o(core_rdata_o)
  );

  int n_checks = 0, n_fail = 0;
  int n_rd = 0, n_wr = 0, n_rd_acc = 0, n_wbeats = 0;
  exp_t exp_q [2][$];
  int   order_q[$];
  int   last_core = 0;
  bit   have_last = 0;
  logic [LINE_W-1:0] mem     [logic [31:0]];  // contents held by the bmem responder
  logic [LINE_W-1:0] ref_mem [logic [31:0]];  // reference image used for expectations

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Default contents of a never-written line, derived from its address.
  function automatic logic [LINE_W-1:0] init_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*BEAT_W +: BEAT_W] = {a ^ 32'hdead_0000, a + 32'(i) * 32'h0101_0101};
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_line(a);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Drive one request and record what the response must be.
  task automatic issue(input int c, input logic w, input logic [31:0] a, input logic [LINE_W-1:0] d);
    exp_t e;
    e.we   = w;
    e.line = a & ~32'h1f;
    if (w) begin
      ref_mem[e.line] = d;
      e.data = d;
      n_wr++;
    end else begin
      e.data = ref_mem.exists(e.line) ? ref_mem[e.line] : init_line(e.line);
      n_rd++;
    end
    exp_q[c].push_back(e);
    c_we[c]    = w;
    c_addr[c]  = a;
    c_wdata[c] = d;
    c_req[c]   = 1'b1;
  endtask

  // Hold the request until the matching resp appears, with a bounded wait.
  task automatic wait_resp(input int c);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (core_resp_o[c]) begin
        c_req[c] = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL resp_timeout core%0d: got no resp in 2000 cycles, required one", c);
    c_req[c] = 1'b0;
  endtask

  task automatic run_core(input int c, input int n);
    logic [31:0] base;
    base = (c == 0) ? 32'h1000_0000 : 32'h2000_0000;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(c, 1'($urandom_range(0, 1)),
            base | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31)), rand_line());
      wait_resp(c);
    end
  endtask

  // Monitor: compare every resp against the head of that core's queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && |core_resp_o) begin
        check("resp_onehot", {255'd0, core_resp_o == 2'b11}, '0);
        for (int c = 0; c < 2; c++) begin
          if (core_resp_o[c]) begin
            if (exp_q[c].size() == 0) begin
              check($sformatf("unexpected_resp_c%0d", c), 1, 0);
            end else begin
              e = exp_q[c].pop_front();
              if (e.we) check($sformatf("wr_line_c%0d_%h", c, e.line), mem_line(e.line), e.data);
              else      check($sformatf("rd_data_c%0d_%h", c, e.line), core_rdata_o, e.data);
              if (order_q.size() > 0) check("arb_order", LINE_W'(c), LINE_W'(order_q.pop_front()));
              last_core = c;
              have_last = 1;
            end
          end
        end
      end
    end
  end

  // bmem responder: sample at negedge, drive just after posedge.
  initial begin
    int                wbeat = 0, rbeat = 0;
    bit                ract = 0;
    logic [31:0]       waddr = '0, raddr_cur = '0;
    logic [LINE_W-1:0] wline = '0, rline = '0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bmem_read || bmem_write) begin
          check("rd_wr_exclusive", {255'd0, bmem_read && bmem_write}, '0);
          check("addr_aligned", LINE_W'(bmem_addr[4:0]), '0);
        end
        if (bmem_write && bmem_ready) begin
          if (wbeat == 0) waddr = bmem_addr;
          else            check("wr_addr_const", LINE_W'(bmem_addr), LINE_W'(waddr));
          wline[wbeat*BEAT_W +: BEAT_W] = bmem_wdata;
          wbeat++;
          n_wbeats++;
          if (wbeat == BEATS) begin
            mem[waddr] = wline;
            wbeat = 0;
          end
        end
        if (ract && bmem_rvalid && bmem_raddr == raddr_cur) begin
          rbeat++;
          if (rbeat == BEATS) ract = 0;
        end
        if (bmem_read && bmem_ready) begin
          n_rd_acc++;
          ract      = 1;
          raddr_cur = bmem_addr;
          rbeat     = 0;
          rline     = mem_line(bmem_addr);
        end
      end
      @(posedge clk);
      #1;
      bmem_ready  = ($urandom_range(0, 3) != 0);
      bmem_rvalid = 1'b0;
      if (ract) begin
        if ($urandom_range(0, 3) != 0) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = raddr_cur;
          bmem_rdata  = rline[rbeat*BEAT_W +: BEAT_W];
        end else if ($urandom_range(0, 1) == 1) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = raddr_cur ^ 32'h0000_0400;
          bmem_rdata  = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin
    int first;
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_bmem_read",  LINE_W'(bmem_read),  '0);
      check("rst_bmem_write", LINE_W'(bmem_write), '0);
      check("rst_bmem_addr",  LINE_W'(bmem_addr),  '0);
      check("rst_bmem_wdata", LINE_W'(bmem_wdata), '0);
      check("rst_resp",       LINE_W'(core_resp_o), '0);
    end
    rst = 1'b1;

    issue(0, 1'b0, 32'h1eceb000, '0);
    wait_resp(0);
    issue(1, 1'b1, 32'h00001020,
          {64'h4444_4444_dddd_dddd, 64'h3333_3333_cccc_cccc, 64'h2222_2222_bbbb_bbbb, 64'h1111_1111_aaaa_aaaa});
    wait_resp(1);
    issue(1, 1'b0, 32'h00001020, '0);
    wait_resp(1);

    // Both cores request in the same cycle, twice.
    for (int r = 0; r < 2; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      first = have_last ? 1 - last_core : 0;
`else
      first = 0;
`endif
      order_q.push_back(first);
      order_q.push_back(1 - first);
      issue(0, 1'b0, 32'h1000_0040 + 32'(r) * 32'h20, '0);
      issue(1, 1'b0, 32'h2000_0040 + 32'(r) * 32'h20, '0);
      fork
        wait_resp(0);
        wait_resp(1);
      join
    end

    fork
      run_core(0, 150);
      run_core(1, 150);
    join
    repeat (5) @(negedge clk);

    check("reads_accepted", LINE_W'(n_rd_acc), LINE_W'(n_rd));
    check("write_beats", LINE_W'(n_wbeats), LINE_W'(n_wr * BEATS));
    check("queue0_drained", LINE_W'(exp_q[0].size()), '0);
    check("queue1_drained", LINE_W'(exp_q[1].size()), '0);
    check("order_drained", LINE_W'(order_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
